pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the 5-stage core. It merges per-stage stall requests into the 6-bit `stall` vector consumed by the PC register and the stage latches. It sequences exception and `eret` redirection as a two-step freeze-then-flush, driving `flush` and `new_pc` to the PC register. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- `EXC_VECTOR`, default 32'h00000020: redirect target for every non-`eret` exception.
- `ERET_CODE`, default 32'h0000000e: `excepttype_i` value that selects `cp0_epc_i` as the target.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset (`RstEnable` = 1).
- `stallreq_if` in 1: fetch stage requests a hold (e.g. bus busy).
- `stallreq_id` in 1: decode stage requests a hold (load-use hazard).
- `stallreq_ex` in 1: execute stage requests a hold (multi-cycle op).
- `stallreq_mem` in 1: memory stage requests a hold.
- `excepttype_i` in 32: exception code from the memory stage; 0 means no exception.
- `cp0_epc_i` in 32: current EPC from CP0.
- `stall` out 6: hold vector. Bit 0 = pc, 1 = if/id, 2 = id/ex, 3 = ex/mem, 4 = mem/wb, 5 = wb.
- `flush` out 1: one-cycle pulse that clears all stage latches and loads `new_pc` into the PC register.
- `new_pc` out 32: redirect address, valid while `flush`=1.
- `stall_cycles_o` out 32: count of request-driven stall cycles.

## Operation
- The FSM has two states, RUN and FLUSH. Reset sets state=RUN, `flush`=0, `new_pc`=0, `stall_cycles_o`=0. `stall` reads 0 out of reset.
- `stall` is combinational from the state and the inputs. `flush` and `new_pc` are registered.
- RUN, with `excepttype_i` != 0:
  - `stall`=6'b111111 this cycle (freeze); all stall requests are ignored.
  - At the clock edge, `new_pc` <= (`excepttype_i`==`ERET_CODE`) ? `cp0_epc_i` : `EXC_VECTOR`, `flush` <= 1, state <= FLUSH.
- RUN, with `excepttype_i` == 0, uses a priority stall encoding (highest first):
  - `stallreq_mem` → 6'b011111.
  - `stallreq_ex` → 6'b001111.
  - `stallreq_id` → 6'b000111.
  - `stallreq_if` → 6'b000011.
  - none → 6'b000000.
- FLUSH:
  - `stall`=0, `flush`=1, and `new_pc` is held.
  - All inputs are ignored, including a new nonzero `excepttype_i` and any stall request.
  - At the clock edge, `flush` <= 0 and state <= RUN. `new_pc` keeps its value.
- Counter:
  - Increments by 1 at each edge where state=RUN, `excepttype_i`==0 and any stallreq is 1.
  - Saturates at 32'hFFFFFFFF.
  - Freeze and FLUSH cycles are not counted.

## Timing
- Exception seen in cycle T:
  - T: freeze, `stall`=6'b111111.
  - T+1: `flush`=1, `stall`=0, and the PC register loads `new_pc` at the end of T+1.
  - T+2: RUN, and the fetch from the target begins.
  - Redirect latency: 2 cycles from exception to PC = target.
- Stall requests take effect in the same cycle (combinational path). The PC register holds on the same edge.
- Back-to-back exceptions: the one in T is taken. A nonzero code in T+1 is dropped. A code in T+2 starts a new freeze.
- `flush` is never high for two consecutive cycles, and is never high together with a nonzero `stall`.
- Reset during FLUSH: the next cycle has `flush`=0, state=RUN, `new_pc`=0, and the counter is cleared.
- Reset overrides every input at the same edge.

## Test plan
- Reset, then hold all inputs at 0 → `stall`=0, `flush`=0, `new_pc`=0, `stall_cycles_o`=0 for 5 cycles.
- Priority:
  - `stallreq_id`=1 and `stallreq_ex`=1 together → `stall`=6'b001111.
  - Add `stallreq_mem` → 6'b011111.
  - Only `stallreq_if` → 6'b000011.
- Exception: `excepttype_i`=32'h8 for 1 cycle with `stallreq_mem`=1 → `stall`=6'b111111 that cycle. Next cycle: `flush`=1, `new_pc`=32'h20, `stall`=0. Then `flush`=0.
- Eret: `excepttype_i`=32'he, `cp0_epc_i`=32'hbfc00100 → one cycle later `flush`=1, `new_pc`=32'hbfc00100.
- Back-to-back: `excepttype_i`=32'hc for 2 cycles → exactly one `flush` pulse. Codes 32'h8 in T+2 → a second pulse in T+3.
- Counter: `stallreq_ex` high for 7 cycles → `stall_cycles_o`=7. Start it at 32'hFFFFFFFE and hold `stallreq_ex` for 5 cycles → saturates at 32'hFFFFFFFF.
- Reset asserted in the FLUSH cycle → the next cycle has `flush`=0, `new_pc`=0, `stall_cycles_o`=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl - pipeline control unit for the 5-stage core.
//
// Merges per-stage stall requests into the stall hold vector. Sequences
// exception and eret redirection as freeze (one cycle, all stages held)
// followed by flush (one cycle, new_pc loaded into the PC register).
// Counts the cycles stalled by stage requests, saturating at all-ones.
//
// Ports:
//   clk            - clock, all state updates on the rising edge
//   rst            - synchronous active-high reset
//   stallreq_if    - fetch stage hold request
//   stallreq_id    - decode stage hold request
//   stallreq_ex    - execute stage hold request
//   stallreq_mem   - memory stage hold request
//   excepttype_i   - exception code from memory stage, 0 = none
//   cp0_epc_i      - current EPC from CP0
//   stall          - hold vector {wb, mem/wb, ex/mem, id/ex, if/id, pc}
//   flush          - one-cycle pulse: clear stage latches, load new_pc
//   new_pc         - redirect address, valid while flush is high
//   stall_cycles_o - saturating count of request-driven stall cycles
//
// CNT_INIT is the counter's reset value; it stays 0 in the core and is
// only moved to start a measurement window near a chosen value.

module pipe_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
   parameter logic [31:0] ERET_CODE  = 32'h0000_000e,
   parameter logic [31:0] CNT_INIT   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [31:0] stall_cycles_o
);

   typedef enum logic {
      S_RUN,
      S_FLUSH
   } state_t;

   state_t state;
   logic   exc_pend;
   logic   any_req;

   assign exc_pend = (excepttype_i != '0);
   assign any_req  = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;

   // Hold vector: the requesting stage and everything upstream of it hold.
   always_comb begin
      stall = '0;
      if (state == S_RUN) begin
         if (exc_pend)          stall = '1;
         else if (stallreq_mem) stall = 6'b011111;
         else if (stallreq_ex)  stall = 6'b001111;
         else if (stallreq_id)  stall = 6'b000111;
         else if (stallreq_if)  stall = 6'b000011;
         else                   stall = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_RUN;
         flush          <= 1'b0;
         new_pc         <= '0;
         stall_cycles_o <= CNT_INIT;
      end else begin
         case (state)
            S_RUN: begin
               if (exc_pend) begin
                  new_pc <= (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
                  flush  <= 1'b1;
                  state  <= S_FLUSH;
               end else if (any_req && (stall_cycles_o != '1)) begin
                  stall_cycles_o <= stall_cycles_o + 32'd1;
               end
            end
            S_FLUSH: begin
               // Every input is ignored here; new_pc keeps its value.
               flush <= 1'b0;
               state <= S_RUN;
            end
            default: begin
               flush <= 1'b0;
               state <= S_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl - self-checking bench for pipe_ctrl.
// Two instances share all inputs: u_dut with default parameters and u_sat
// whose counter resets to 32'hFFFFFFFE so saturation is reachable.

module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
   logic [31:0] excepttype_i, cp0_epc_i;
   logic [5:0]  stall, stall_s;
   logic        flush, flush_s;
   logic [31:0] new_pc, new_pc_s;
   logic [31:0] cnt, cnt_s;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] EXC_VEC = 32'h0000_0020;
   localparam logic [31:0] ERET    = 32'h0000_000e;
   localparam logic [31:0] SAT_INI = 32'hFFFF_FFFE;
   localparam longint unsigned MAXC = 64'h0000_0000_FFFF_FFFF;

   pipe_ctrl u_dut (
      .clk(clk), .rst(rst),
      .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
      .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
      .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
      .stall(stall), .flush(flush), .new_pc(new_pc), .stall_cycles_o(cnt)
   );

   pipe_ctrl #(.CNT_INIT(SAT_INI)) u_sat (
      .clk(clk), .rst(rst),
      .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
      .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
      .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
      .stall(stall_s), .flush(flush_s), .new_pc(new_pc_s), .stall_cycles_o(cnt_s)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model ----------------
   bit              m_valid   = 1'b0;
   bit              m_inflush = 1'b0;
   logic [31:0]     m_pc      = '0;
   longint unsigned m_cnt0    = 0;
   longint unsigned m_cnt1    = 0;
   bit              prev_flush = 1'b0;

   function automatic longint unsigned sat_inc(longint unsigned v);
      return (v + 1 > MAXC) ? MAXC : v + 1;
   endfunction

   // Deepest requesting stage decides how many low bits of the vector hold.
   function automatic logic [5:0] exp_stall();
      int lvl;
      if (m_inflush) return 6'd0;
      if (excepttype_i != 0) return 6'd63;
      lvl = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : stallreq_if ? 2 : 0;
      return 6'((1 << lvl) - 1);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_valid   <= 1'b1;
         m_inflush <= 1'b0;
         m_pc      <= '0;
         m_cnt0    <= 0;
         m_cnt1    <= longint'(SAT_INI);
      end else if (m_inflush) begin
         m_inflush <= 1'b0;
      end else if (excepttype_i != 0) begin
         m_inflush <= 1'b1;
         m_pc      <= (excepttype_i == ERET) ? cp0_epc_i : EXC_VEC;
      end else if (stallreq_if || stallreq_id || stallreq_ex || stallreq_mem) begin
         m_cnt0 <= sat_inc(m_cnt0);
         m_cnt1 <= sat_inc(m_cnt1);
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Single compare process, two time units after each falling edge.
   always @(negedge clk) begin
      #2;
      if (m_valid) begin
         chk("stall",      32'(stall),   32'(exp_stall()));
         chk("flush",      32'(flush),   32'(m_inflush));
         chk("new_pc",     new_pc,       m_pc);
         chk("cnt",        cnt,          m_cnt0[31:0]);
         chk("sat_stall",  32'(stall_s), 32'(exp_stall()));
         chk("sat_flush",  32'(flush_s), 32'(m_inflush));
         chk("sat_new_pc", new_pc_s,     m_pc);
         chk("sat_cnt",    cnt_s,        m_cnt1[31:0]);
         if (flush) chk("flush_with_stall", 32'(stall), 32'd0);
         chk("flush_twice", 32'(prev_flush & flush), 32'd0);
         prev_flush = flush;
      end
   end

   // Applies one cycle of inputs just after a falling edge.
   task automatic drive(bit r, bit f, bit d, bit e, bit m,
                        logic [31:0] exc, logic [31:0] epc);
      @(negedge clk);
      rst = r; stallreq_if = f; stallreq_id = d; stallreq_ex = e; stallreq_mem = m;
      excepttype_i = exc; cp0_epc_i = epc;
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 32'd0, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
      excepttype_i = '0; cp0_epc_i = '0;

      drive(1, 0, 0, 0, 0, 32'd0, 32'd0);
      drive(1, 0, 0, 0, 0, 32'd0, 32'd0);

      // Reset state held for 5 idle cycles.
      for (int i = 0; i < 5; i++) begin
         idle();
         chk("rst_stall", 32'(stall), 32'd0);
         chk("rst_flush", 32'(flush), 32'd0);
         chk("rst_new_pc", new_pc, 32'd0);
         chk("rst_cnt", cnt, 32'd0);
      end

      // Priority encoding.
      drive(0, 0, 1, 1, 0, 32'd0, 32'd0);
      chk("prio_id_ex", 32'(stall), 32'h0f);
      drive(0, 0, 1, 1, 1, 32'd0, 32'd0);
      chk("prio_mem", 32'(stall), 32'h1f);
      drive(0, 1, 0, 0, 0, 32'd0, 32'd0);
      chk("prio_if", 32'(stall), 32'h03);

      // Exception with a concurrent memory stall request.
      drive(0, 0, 0, 0, 1, 32'h8, 32'd0);
      chk("exc_freeze", 32'(stall), 32'h3f);
      idle();
      chk("exc_flush", 32'(flush), 32'd1);
      chk("exc_new_pc", new_pc, 32'h20);
      chk("exc_flush_stall", 32'(stall), 32'd0);
      idle();
      chk("exc_flush_end", 32'(flush), 32'd0);

      // eret redirects to EPC.
      drive(0, 0, 0, 0, 0, 32'he, 32'hbfc00100);
      chk("eret_freeze", 32'(stall), 32'h3f);
      idle();
      chk("eret_flush", 32'(flush), 32'd1);
      chk("eret_new_pc", new_pc, 32'hbfc00100);
      idle();

      // Back-to-back codes: T taken, T+1 dropped, T+2 starts a new freeze.
      drive(0, 0, 0, 0, 0, 32'hc, 32'd0);
      drive(0, 0, 0, 1, 0, 32'hc, 32'd0);
      chk("b2b_flush1", 32'(flush), 32'd1);
      chk("b2b_ignored", 32'(stall), 32'd0);
      drive(0, 0, 0, 0, 0, 32'h8, 32'd0);
      chk("b2b_gap", 32'(flush), 32'd0);
      chk("b2b_freeze2", 32'(stall), 32'h3f);
      idle();
      chk("b2b_flush2", 32'(flush), 32'd1);
      chk("b2b_new_pc2", new_pc, 32'h20);
      idle();
      chk("b2b_end", 32'(flush), 32'd0);

      // Counter and saturation.
      drive(1, 0, 0, 0, 0, 32'd0, 32'd0);
      for (int i = 0; i < 7; i++) begin
         drive(0, 0, 0, 1, 0, 32'd0, 32'd0);
         if (i == 5) begin
            chk("cnt_5", cnt, 32'd5);
            chk("cnt_sat_5", cnt_s, 32'hFFFFFFFF);
         end
      end
      idle();
      chk("cnt_7", cnt, 32'd7);
      chk("cnt_sat_7", cnt_s, 32'hFFFFFFFF);

      // Reset during the flush cycle.
      drive(0, 0, 0, 0, 0, 32'h8, 32'd0);
      drive(1, 0, 0, 0, 0, 32'd0, 32'd0);
      chk("rstfl_flush_before", 32'(flush), 32'd1);
      idle();
      chk("rstfl_flush", 32'(flush), 32'd0);
      chk("rstfl_new_pc", new_pc, 32'd0);
      chk("rstfl_cnt", cnt, 32'd0);
      chk("rstfl_cnt_sat", cnt_s, 32'hFFFFFFFE);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         int unsigned sel;
         logic [31:0] exc;
         sel = $urandom_range(0, 9);
         case (sel)
            0:       exc = ERET;
            1:       exc = $urandom | 32'h1;
            2:       exc = 32'h8;
            default: exc = 32'd0;
         endcase
         drive(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), exc, $urandom);
      end
      idle();
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
